// File: rtl/dff_bank_pkg.sv
// Shared definitions for the DFF bank arbiter.
//   cmd_e   : per-requester command encoding (2 bits)
//   state_e : controller FSM state encoding
//   DEF_N_REQ / DEF_WIDTH : default requester count and bank width
//   OPS_MAX : saturation value of the completed-command counter
//   idx_width() : bits needed to hold a requester index (minimum 1)
package dff_bank_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int OPS_W     = 8;
    localparam logic [OPS_W-1:0] OPS_MAX = '1;

    typedef enum logic [1:0] {
        CMD_WRITE  = 2'b00,
        CMD_PRESET = 2'b01,
        CMD_CLEAR  = 2'b10,
        CMD_NOP    = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARB   = 2'b01,
        ST_APPLY = 2'b10
    } state_e;

    // A single requester still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the DFF bank arbiter.
//   req   : per-requester request, held until its gnt is seen
//   cmd   : per-requester command, bits [2i+1:2i]
//   wdata : per-requester write data, bits [WIDTH*i +: WIDTH]
//   gnt   : one-hot grant pulse (one cycle)
//   q     : bank contents
//   qbar  : complement of q
//   busy  : controller is not idle
//   ops   : saturating count of completed commands
// master = requester side, slave = arbiter side.
interface dff_bank_arbiter_if
    import dff_bank_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     cmd;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       qbar;
    logic                   busy;
    logic [OPS_W-1:0]       ops;

    modport master (
        output req, cmd, wdata,
        input  gnt, q, qbar, busy, ops
    );

    modport slave (
        input  req, cmd, wdata,
        output gnt, q, qbar, busy, ops
    );

endinterface

// File: rtl/dff_bit.sv
// One bank bit: D flip-flop with synchronous clear and preset.
//   clk  : rising-edge clock
//   d    : data input, loaded when neither clr nor pre is high
//   pre  : synchronous preset (q <= 1)
//   clr  : synchronous clear (q <= 0), wins over pre
//   q    : stored bit
//   qbar : complement of q
module dff_bit (
    input  logic clk,
    input  logic d,
    input  logic pre,
    input  logic clr,
    output logic q,
    output logic qbar
);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b0;
        end else if (pre) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters apply WRITE / PRESET /
// CLEAR / NOP commands to a shared WIDTH-bit register bank.
//   clk : rising-edge clock
//   clr : synchronous active-high reset, overrides every FSM action
//   bus : requester bus (slave side), see dff_bank_arbiter_if
// Each command takes three cycles: IDLE captures the winner and its command,
// ARB raises the grant, APPLY drops the grant and updates bank, ptr and ops.
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    dff_bank_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam logic [N_REQ-1:0] GNT_ONE = 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    state_e             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win_idx;
    cmd_e               cap_cmd;
    logic [WIDTH-1:0]   cap_wdata;
    logic [N_REQ-1:0]   gnt_r;
    logic               busy_r;
    logic [OPS_W-1:0]   ops_r;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;

    logic [WIDTH-1:0]   bank_d;
    logic [WIDTH-1:0]   bank_q;
    logic [WIDTH-1:0]   bank_qbar;
    logic               apply_now;
    logic               bit_pre;
    logic               bit_clr;

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        int cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (!rr_found && bus.req[IDX_W'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            win_idx   <= '0;
            cap_cmd   <= CMD_NOP;
            cap_wdata <= '0;
            gnt_r     <= '0;
            busy_r    <= 1'b0;
            ops_r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        // Snapshot the winner's command so later input
                        // changes cannot alter this operation.
                        win_idx   <= rr_idx;
                        cap_cmd   <= cmd_e'(bus.cmd[2*int'(rr_idx) +: 2]);
                        cap_wdata <= bus.wdata[WIDTH*int'(rr_idx) +: WIDTH];
                        state     <= ST_ARB;
                        busy_r    <= 1'b1;
                    end
                end
                ST_ARB: begin
                    gnt_r <= GNT_ONE << win_idx;
                    state <= ST_APPLY;
                end
                ST_APPLY: begin
                    gnt_r  <= '0;
                    ptr    <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
                    if (ops_r != OPS_MAX) begin
                        ops_r <= ops_r + 1'b1;
                    end
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    gnt_r  <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Bank control: the bank updates on the APPLY -> IDLE edge. clr feeds the
    // bit clear directly, and the bit gives clear priority over preset, so an
    // aborted operation never reaches the bank.
    assign apply_now = (state == ST_APPLY);
    assign bit_clr   = clr | (apply_now && cap_cmd == CMD_CLEAR);
    assign bit_pre   = apply_now && cap_cmd == CMD_PRESET;
    assign bank_d    = (apply_now && cap_cmd == CMD_WRITE) ? cap_wdata : bank_q;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bank
        dff_bit u_bit (
            .clk  (clk),
            .d    (bank_d[b]),
            .pre  (bit_pre),
            .clr  (bit_clr),
            .q    (bank_q[b]),
            .qbar (bank_qbar[b])
        );
    end

    assign bus.gnt  = gnt_r;
    assign bus.busy = busy_r;
    assign bus.ops  = ops_r;
    assign bus.q    = bank_q;
    assign bus.qbar = bank_qbar;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter (N_REQ=4, WIDTH=8).
// Directed scenarios plus randomized traffic, all checked against a
// transaction-level model: pending-request mask, round-robin pointer,
// bank value and saturating op count.
module tb_dff_bank_arbiter;
    import dff_bank_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    dff_bank_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    dff_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_ptr;
    int         m_ops;
    logic [7:0] m_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [1:0] c, input logic [7:0] d);
        bus.req[i]         = 1'b1;
        bus.cmd[2*i +: 2]  = c;
        bus.wdata[8*i +: 8] = d;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        logic [1:0] k;
        for (int i = 0; i < N; i++) begin
            k = 2'((p + i) % N);
            if (r[k]) return int'(k);
        end
        return 0;
    endfunction

    function automatic logic [7:0] model_apply(input logic [1:0] c, input logic [7:0] d,
                                               input logic [7:0] q);
        case (c)
            2'b00:   return d;
            2'b01:   return 8'hFF;
            2'b10:   return 8'h00;
            default: return q;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_ops = 0;
        m_q   = 8'h00;
    endtask

    task automatic do_reset();
        clr       = 1'b1;
        bus.req   = '0;
        tick();
        tick();
        clr = 1'b0;
        model_reset();
    endtask

    // One full operation, starting at a negedge with the DUT idle and the
    // requests already driven. want_win >= 0 names the winner explicitly.
    task automatic expect_op(input int want_win, input bit scramble, input bit release_win);
        int         win;
        logic [1:0] c;
        logic [7:0] d;
        logic [3:0] exp_g;
        win = (want_win >= 0) ? want_win : rr_pick(bus.req, m_ptr);
        c   = bus.cmd[2*win +: 2];
        d   = bus.wdata[8*win +: 8];
        exp_g = 4'b0001 << win;

        tick();  // after E0: arbitration cycle
        check("arb_busy", {31'd0, bus.busy}, 32'd1);
        check("arb_gnt",  {28'd0, bus.gnt}, 32'd0);
        if (scramble) begin
            // Captured command must ignore these changes.
            bus.cmd[2*win +: 2]   = 2'($urandom);
            bus.wdata[8*win +: 8] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) bus.req[win] = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j != win && !bus.req[j] && $urandom_range(0, 2) == 0)
                    set_req(j, 2'($urandom), 8'($urandom));
            end
        end

        tick();  // after E1: grant cycle
        check("apply_gnt",  {28'd0, bus.gnt}, {28'd0, exp_g});
        check("apply_busy", {31'd0, bus.busy}, 32'd1);
        check("apply_q_hold", {24'd0, bus.q}, {24'd0, m_q});

        tick();  // after E2: bank and ops updated
        m_q   = model_apply(c, d, m_q);
        m_ops = (m_ops < 255) ? m_ops + 1 : 255;
        m_ptr = (win + 1) % N;
        check("done_gnt",  {28'd0, bus.gnt}, 32'd0);
        check("done_busy", {31'd0, bus.busy}, 32'd0);
        check("done_q",    {24'd0, bus.q}, {24'd0, m_q});
        check("done_qbar", {24'd0, bus.qbar}, {24'd0, ~m_q});
        check("done_ops",  {24'd0, bus.ops}, m_ops);
        if (release_win) bus.req[win] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req   = '0;
        bus.cmd   = '1;
        bus.wdata = '0;
        clr       = 1'b1;
        model_reset();

        // Reset state
        tick();
        tick();
        check("rst_q",    {24'd0, bus.q}, 32'h00);
        check("rst_qbar", {24'd0, bus.qbar}, 32'hFF);
        check("rst_gnt",  {28'd0, bus.gnt}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ops",  {24'd0, bus.ops}, 32'd0);
        clr = 1'b0;

        // Single write from requester 2
        set_req(2, CMD_WRITE, 8'hA5);
        expect_op(2, 1'b0, 1'b1);
        check("write_q_a5",    {24'd0, bus.q}, 32'hA5);
        check("write_qbar_5a", {24'd0, bus.qbar}, 32'h5A);
        check("write_ops_1",   {24'd0, bus.ops}, 32'd1);

        // PRESET, CLEAR, then NOP on a known value
        set_req(1, CMD_PRESET, 8'h00);
        expect_op(1, 1'b0, 1'b1);
        check("preset_q", {24'd0, bus.q}, 32'hFF);
        set_req(0, CMD_CLEAR, 8'h5A);
        expect_op(0, 1'b0, 1'b1);
        check("clear_q", {24'd0, bus.q}, 32'h00);
        set_req(3, CMD_WRITE, 8'h3C);
        expect_op(3, 1'b0, 1'b1);
        set_req(3, CMD_NOP, 8'hFF);
        expect_op(3, 1'b0, 1'b1);
        check("nop_q",   {24'd0, bus.q}, 32'h3C);
        check("nop_ops", {24'd0, bus.ops}, 32'd5);

        // Round-robin with all requests held: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, CMD_WRITE, 8'(8'h10 + i));
        expect_op(0, 1'b0, 1'b0);
        expect_op(1, 1'b0, 1'b0);
        expect_op(2, 1'b0, 1'b0);
        expect_op(3, 1'b0, 1'b0);
        expect_op(0, 1'b0, 1'b0);
        bus.req = '0;

        // Abort in ARB, then arbitration restarts at index 0
        do_reset();
        set_req(2, CMD_WRITE, 8'h11);
        expect_op(2, 1'b0, 1'b1);          // ptr now 3
        set_req(1, CMD_WRITE, 8'h77);
        tick();                            // in ARB
        check("abort_pre_busy", {31'd0, bus.busy}, 32'd1);
        clr = 1'b1;
        tick();
        check("abort_gnt",  {28'd0, bus.gnt}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_q",    {24'd0, bus.q}, 32'h00);
        check("abort_qbar", {24'd0, bus.qbar}, 32'hFF);
        check("abort_ops",  {24'd0, bus.ops}, 32'd0);
        tick();
        check("abort_no_gnt", {28'd0, bus.gnt}, 32'd0);
        clr = 1'b0;
        model_reset();
        set_req(3, CMD_WRITE, 8'h33);      // req = 1010; index 1 must win
        expect_op(1, 1'b0, 1'b1);
        check("abort_next_q", {24'd0, bus.q}, 32'h77);
        bus.req = '0;

        // Saturation: 260 back-to-back NOPs
        do_reset();
        set_req(0, CMD_NOP, 8'h00);
        for (int i = 0; i < 260; i++) expect_op(0, 1'b0, 1'b0);
        bus.req = '0;
        check("sat_ops", {24'd0, bus.ops}, 32'd255);
        tick();
        tick();
        check("sat_hold_ops",  {24'd0, bus.ops}, 32'd255);
        check("sat_hold_busy", {31'd0, bus.busy}, 32'd0);

        // Randomized traffic with pending requests and post-capture changes
        do_reset();
        for (int n = 0; n < 200; n++) begin
            for (int j = 0; j < N; j++) begin
                if (!bus.req[j] && $urandom_range(0, 1) == 1)
                    set_req(j, 2'($urandom), 8'($urandom));
            end
            if (bus.req == '0) set_req($urandom_range(0, N-1), 2'($urandom), 8'($urandom));
            expect_op(-1, 1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
